// File: rtl/uart_frame_loader_if.sv
// UART receive line plus frame-buffer write port of uart_frame_loader.
// master = stimulus/consumer side, slave = the loader itself.
interface uart_frame_loader_if #(parameter int AW = 8);
  logic          rx_in;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [2:0]    wr_data;
  logic          busy;
  logic          frame_done;
  logic          err;

  modport master (output rx_in, input wr_en, wr_addr, wr_data, busy, frame_done, err);
  modport slave  (input rx_in, output wr_en, wr_addr, wr_data, busy, frame_done, err);
endinterface

// File: rtl/uart_frame_loader.sv
// 8N1 UART receiver + 0xA5-synced frame parser writing 3-bit pixels into the panel frame buffer.
// Optional trailing checksum byte: define UART_FRAME_LOADER_CHECKSUM_EN.
module uart_frame_loader #(
  parameter int CLKS_PER_BIT = 104,
  parameter int ROWS         = 8,
  parameter int COLS         = 32,
  parameter int AW           = $clog2(ROWS*COLS)
) (
  input  logic              clk,
  input  logic              reset,
  uart_frame_loader_if.slave bus
);
  localparam int          NPIX = ROWS*COLS;
  localparam int          CW   = $clog2(CLKS_PER_BIT);
  localparam int          HALF = CLKS_PER_BIT/2;
  localparam logic [7:0]  SYNC = 8'hA5;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_t;
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {P_HUNT, P_LOAD, P_DONE, P_CSUM} ps_t;
`else
  typedef enum logic [1:0] {P_HUNT, P_LOAD, P_DONE} ps_t;
`endif

  // [1:0] synchronizer, [2] one extra stage of history for the falling-edge detect
  logic [2:0] r_sync;
  logic       w_rx, w_fall;

  always_ff @(posedge clk or negedge reset)
    if (!reset) r_sync <= 3'b111;
    else        r_sync <= {r_sync[1:0], bus.rx_in};

  assign w_rx   = r_sync[1];
  assign w_fall = r_sync[2] & ~r_sync[1];

  rx_st_t        r_rx_st, w_rx_st_n;
  logic [CW-1:0] r_bcnt, w_bcnt_n;
  logic [2:0]    r_bitn, w_bitn_n;
  logic [7:0]    r_shift, w_shift_n;
  logic          r_rx_vld, w_rx_vld_n;
  logic          r_rx_ferr, w_rx_ferr_n;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_rx_st   <= RX_IDLE;
      r_bcnt    <= '0;
      r_bitn    <= '0;
      r_shift   <= '0;
      r_rx_vld  <= 1'b0;
      r_rx_ferr <= 1'b0;
    end else begin
      r_rx_st   <= w_rx_st_n;
      r_bcnt    <= w_bcnt_n;
      r_bitn    <= w_bitn_n;
      r_shift   <= w_shift_n;
      r_rx_vld  <= w_rx_vld_n;
      r_rx_ferr <= w_rx_ferr_n;
    end

  // The detect cycle counts as the first cycle of the half-bit wait.
  always_comb begin
    w_rx_st_n   = r_rx_st;
    w_bcnt_n    = r_bcnt + CW'(1);
    w_bitn_n    = r_bitn;
    w_shift_n   = r_shift;
    w_rx_vld_n  = 1'b0;
    w_rx_ferr_n = 1'b0;
    case (r_rx_st)
      RX_IDLE: begin
        w_bcnt_n = CW'(1);
        if (w_fall) w_rx_st_n = RX_START;
      end
      RX_START:
        if (r_bcnt == CW'(HALF-1)) begin
          w_bcnt_n  = '0;
          w_bitn_n  = '0;
          w_rx_st_n = w_rx ? RX_IDLE : RX_DATA;
        end
      RX_DATA:
        if (r_bcnt == CW'(CLKS_PER_BIT-1)) begin
          w_bcnt_n  = '0;
          w_shift_n = {w_rx, r_shift[7:1]};
          w_bitn_n  = r_bitn + 3'd1;
          if (r_bitn == 3'd7) w_rx_st_n = RX_STOP;
        end
      RX_STOP:
        if (r_bcnt == CW'(CLKS_PER_BIT-1)) begin
          w_rx_vld_n  = w_rx;
          w_rx_ferr_n = ~w_rx;
          w_rx_st_n   = RX_IDLE;
        end
      default: w_rx_st_n = RX_IDLE;
    endcase
  end

  ps_t           r_ps, w_ps_n;
  logic [AW-1:0] r_pcnt, w_pcnt_n;
  logic          r_wr_en, w_wr_en_n;
  logic [AW-1:0] r_wr_addr, w_wr_addr_n;
  logic [2:0]    r_wr_data, w_wr_data_n;
  logic          r_err, w_err_n;
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
  logic [7:0]    r_sum, w_sum_n;

  always_ff @(posedge clk or negedge reset)
    if (!reset) r_sum <= '0;
    else        r_sum <= w_sum_n;
`endif

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_ps      <= P_HUNT;
      r_pcnt    <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_err     <= 1'b0;
    end else begin
      r_ps      <= w_ps_n;
      r_pcnt    <= w_pcnt_n;
      r_wr_en   <= w_wr_en_n;
      r_wr_addr <= w_wr_addr_n;
      r_wr_data <= w_wr_data_n;
      r_err     <= w_err_n;
    end

  always_comb begin
    w_ps_n      = r_ps;
    w_pcnt_n    = r_pcnt;
    w_wr_en_n   = 1'b0;
    w_wr_addr_n = r_wr_addr;
    w_wr_data_n = r_wr_data;
    w_err_n     = 1'b0;
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
    w_sum_n     = r_sum;
`endif
    case (r_ps)
      P_HUNT:
        if (r_rx_vld && r_shift == SYNC) begin
          w_ps_n   = P_LOAD;
          w_pcnt_n = '0;
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
          w_sum_n  = '0;
`endif
        end
      P_LOAD: begin
        if (r_rx_ferr) begin
          w_err_n = 1'b1;
          w_ps_n  = P_HUNT;
        end else if (r_rx_vld) begin
          w_wr_en_n   = 1'b1;
          w_wr_addr_n = r_pcnt;
          w_wr_data_n = r_shift[2:0];
          w_pcnt_n    = r_pcnt + AW'(1);
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
          w_sum_n     = r_sum + r_shift;
          if (r_pcnt == AW'(NPIX-1)) w_ps_n = P_CSUM;
        end
`else
        end else if (r_wr_en && r_wr_addr == AW'(NPIX-1)) begin
          // leave LOAD the cycle after the last strobe so done trails it by one
          w_ps_n = P_DONE;
        end
`endif
      end
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
      P_CSUM:
        if (r_rx_ferr) begin
          w_err_n = 1'b1;
          w_ps_n  = P_HUNT;
        end else if (r_rx_vld) begin
          if (r_shift == r_sum) w_ps_n = P_DONE;
          else begin
            w_err_n = 1'b1;
            w_ps_n  = P_HUNT;
          end
        end
`endif
      P_DONE:  w_ps_n = P_HUNT;
      default: w_ps_n = P_HUNT;
    endcase
  end

  assign bus.wr_en      = r_wr_en;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;
  assign bus.err        = r_err;
  assign bus.frame_done = (r_ps == P_DONE);
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
  assign bus.busy       = (r_ps == P_LOAD) || (r_ps == P_CSUM);
`else
  assign bus.busy       = (r_ps == P_LOAD);
`endif
endmodule

// File: tb/tb_uart_frame_loader.sv
// Bench for uart_frame_loader: directed table frame, hand-written corner sequences and
// randomized frames checked against a frame-level reference model of the byte stream.
module tb_uart_frame_loader;
  localparam int CPB  = 16;
  localparam int ROWS = 4;
  localparam int COLS = 8;
  localparam int NPIX = ROWS*COLS;
  localparam int AW   = $clog2(NPIX);
  localparam int EV_W = 0, EV_D = 1, EV_E = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;

  uart_frame_loader_if #(.AW(AW)) bus();

  uart_frame_loader #(.CLKS_PER_BIT(CPB), .ROWS(ROWS), .COLS(COLS), .AW(AW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct { int kind; int addr; int data; int cyc; } ev_t;
  typedef struct { logic [7:0] din; logic [AW-1:0] exp_addr; logic [2:0] exp_data; } vec_t;

  ev_t        mon_q[$], exp_q[$];
  logic [7:0] tx_b[$];
  bit         tx_f[$];
  int         cyc = 0, t_start = 0;
  int         n_tests = 0, n_fail = 0, bad_rule = 0;
  logic       prev_busy = 1'b0;

  function automatic ev_t mk(input int kind, input int addr, input int data);
    ev_t e;
    e.kind = kind; e.addr = addr; e.data = data; e.cyc = 0;
    return e;
  endfunction

  function automatic int pk(input ev_t e);
    return e.kind*4096 + e.addr*8 + e.data;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    ev_t e;
    if (bus.wr_en) begin
      e = mk(EV_W, int'(bus.wr_addr), int'(bus.wr_data)); e.cyc = cyc; mon_q.push_back(e);
    end
    if (bus.frame_done) begin e = mk(EV_D, 0, 0); e.cyc = cyc; mon_q.push_back(e); end
    if (bus.err)        begin e = mk(EV_E, 0, 0); e.cyc = cyc; mon_q.push_back(e); end
    if ((bus.frame_done || bus.err) && (bus.busy || !prev_busy || (bus.frame_done && bus.err)))
      bad_rule++;
    prev_busy = bus.busy;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit ferr, input int gap);
    tx_b.push_back(b); tx_f.push_back(ferr);
    @(negedge clk); bus.rx_in = 1'b0; t_start = cyc;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx_in = b[i];
      repeat (CPB) @(negedge clk);
    end
    bus.rx_in = !ferr;
    repeat (CPB) @(negedge clk);
    bus.rx_in = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  // Frame-level reading of the stream: sync byte, NPIX pixels, optional checksum.
  task automatic model();
    int i, k, sum;
    bit ab;
    exp_q.delete();
    i = 0;
    while (i < tx_b.size()) begin
      if (tx_f[i] || tx_b[i] != 8'hA5) i++;
      else begin
        i++; k = 0; sum = 0; ab = 0;
        while (!ab && k < NPIX && i < tx_b.size()) begin
          if (tx_f[i]) begin exp_q.push_back(mk(EV_E, 0, 0)); ab = 1; end
          else begin
            exp_q.push_back(mk(EV_W, k, int'(tx_b[i]) % 8));
            sum += int'(tx_b[i]);
            k++;
          end
          i++;
        end
        if (!ab && k == NPIX) begin
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
          if (i < tx_b.size()) begin
            if (!tx_f[i] && int'(tx_b[i]) == sum % 256) exp_q.push_back(mk(EV_D, 0, 0));
            else exp_q.push_back(mk(EV_E, 0, 0));
            i++;
          end
`else
          exp_q.push_back(mk(EV_D, 0, 0));
`endif
        end
      end
    end
  endtask

  task automatic run_check(input string name);
    repeat (2*CPB) @(negedge clk);
    model();
    chk({name, "_count"}, mon_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++)
      chk(name, pk(mon_q[i]), pk(exp_q[i]));
    mon_q.delete(); exp_q.delete(); tx_b.delete(); tx_f.delete();
  endtask

  task automatic send_frame_tail(input int start_k, input bit good_csum, input int sum0);
    int sum;
    logic [7:0] b;
    sum = sum0;
    for (int k = start_k; k < NPIX; k++) begin
      b = 8'($urandom_range(0, 255));
      sum += int'(b);
      send_byte(b, 1'b0, ($urandom_range(0, 1) == 1) ? CPB : 0);
    end
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
    if (good_csum) send_byte(8'(sum), 1'b0, CPB);
    else           send_byte(8'(sum + $urandom_range(1, 255)), 1'b0, CPB);
`endif
  endtask

  initial begin
    vec_t vec[NPIX];
    ev_t  e;
    int   last_wr_cyc, tsum;
    logic [7:0] b;

    vec[0] = '{8'h07, AW'(0), 3'b111};
    vec[1] = '{8'hA5, AW'(1), 3'b101};
    vec[2] = '{8'hF8, AW'(2), 3'b000};
    vec[3] = '{8'h3A, AW'(3), 3'b010};
    vec[4] = '{8'hFF, AW'(4), 3'b111};
    for (int k = 5; k < NPIX; k++)
      vec[k] = '{8'((k << 3) | (k % 8)), AW'(k), 3'(k % 8)};

    bus.rx_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {bus.wr_en, bus.wr_addr, bus.wr_data, bus.busy, bus.frame_done, bus.err}, 0);
    reset = 1'b1;
    repeat (4*CPB) @(negedge clk);

    // Directed frame: junk byte ignored, then one table entry per pixel.
    send_byte(8'h3C, 1'b0, CPB);
    chk("junk_busy", bus.busy, 0);
    send_byte(8'hA5, 1'b0, CPB);
    chk("sync_busy", bus.busy, 1);
    chk("junk_no_event", mon_q.size(), 0);
    tsum = 0; last_wr_cyc = 0;
    for (int k = 0; k < NPIX; k++) begin
      send_byte(vec[k].din, 1'b0, (k % 3 == 0) ? 0 : CPB);
      tsum += int'(vec[k].din);
      chk("tbl_wr_present", mon_q.size() > 0, 1);
      if (mon_q.size() > 0) begin
        e = mon_q.pop_front();
        last_wr_cyc = e.cyc;
        chk("tbl_wr", pk(e), EV_W*4096 + int'(vec[k].exp_addr)*8 + int'(vec[k].exp_data));
        if (k == 0) chk("wr_latency", e.cyc - t_start, 2 + CPB/2 + 9*CPB + 1);
      end
    end
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
    send_byte(8'(tsum), 1'b0, CPB);
`endif
    repeat (2*CPB) @(negedge clk);
    chk("tbl_end_count", mon_q.size(), 1);
    if (mon_q.size() > 0) begin
      e = mon_q.pop_front();
      chk("tbl_done", e.kind, EV_D);
`ifndef UART_FRAME_LOADER_CHECKSUM_EN
      chk("done_after_last_wr", e.cyc - last_wr_cyc, 1);
`endif
    end
    chk("tbl_busy_end", bus.busy, 0);
    mon_q.delete(); tx_b.delete(); tx_f.delete();

    // Framing error mid-frame: 10 writes then err, then a fresh sync restarts at address 0.
    send_byte(8'hA5, 1'b0, CPB);
    for (int k = 0; k < 10; k++) send_byte(8'($urandom_range(0, 255)), 1'b0, 0);
    send_byte(8'h5E, 1'b1, CPB);
    chk("ferr_busy_low", bus.busy, 0);
    run_check("ferr");
    send_byte(8'hA5, 1'b0, CPB);
    send_byte(8'h0B, 1'b0, CPB);
    send_byte(8'h03, 1'b0, CPB);
    run_check("restart");
    chk("busy_before_rst", bus.busy, 1);

    // Reset in the DATA phase of the next byte: outputs clear at once, no err.
    @(negedge clk); bus.rx_in = 1'b0;
    repeat (4*CPB) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_mid_outputs", {bus.wr_en, bus.wr_addr, bus.wr_data, bus.busy, bus.frame_done, bus.err}, 0);
    bus.rx_in = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (4*CPB) @(negedge clk);
    chk("rst_silent", mon_q.size(), 0);

    // Glitch inside LOAD is not a byte; 0xA5 inside LOAD is a pixel.
    send_byte(8'hA5, 1'b0, CPB);
    send_byte(8'h11, 1'b0, CPB);
    tsum = 8'h11;
    @(negedge clk); bus.rx_in = 1'b0;
    repeat (3) @(negedge clk);
    bus.rx_in = 1'b1;
    repeat (3*CPB) @(negedge clk);
    send_byte(8'hA5, 1'b0, CPB);
    tsum += 8'hA5;
    send_frame_tail(2, 1'b1, tsum);
    run_check("glitch_a5");
    chk("glitch_busy_end", bus.busy, 0);

`ifdef UART_FRAME_LOADER_CHECKSUM_EN
    for (int pass = 0; pass < 2; pass++) begin
      send_byte(8'hA5, 1'b0, CPB);
      for (int k = 0; k < NPIX; k++) send_byte(8'h01, 1'b0, 0);
      send_byte(8'(NPIX + pass), 1'b0, CPB);
      repeat (2*CPB) @(negedge clk);
      chk("csum_last_event", (mon_q.size() > 0) ? mon_q[mon_q.size()-1].kind : -1,
          (pass == 0) ? EV_D : EV_E);
      run_check("csum");
      chk("csum_busy_end", bus.busy, 0);
    end
`endif

    // Randomized frames with junk, occasional framing errors and bad checksums.
    for (int f = 0; f < 3; f++) begin
      int  nj, fpos;
      bit  good;
      nj = $urandom_range(0, 2);
      for (int j = 0; j < nj; j++) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h5A;
        send_byte(b, 1'b0, CPB);
      end
      send_byte(8'hA5, 1'b0, CPB);
      fpos = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NPIX-1) : -1;
      good = ($urandom_range(0, 2) != 0);
      if (fpos >= 0) begin
        for (int k = 0; k < fpos; k++) send_byte(8'($urandom_range(0, 255)), 1'b0, 0);
        send_byte(8'($urandom_range(0, 255)), 1'b1, CPB);
      end else begin
        send_frame_tail(0, good, 0);
      end
      run_check("rand_frame");
    end

    chk("done_err_busy_rules", bad_rule, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
